// File: rtl/seg_decode.sv
// seg_decode: debounces a two-digit seven-segment display and emits the decoded byte over valid/ready
module seg_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg0_in,
  input  logic [7:0] seg1_in,
  output logic [7:0] out_byte,
  output logic [1:0] out_err,
  output logic       out_valid,
  input  logic       out_ready
);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, OUTPUT = 2'd2;
  localparam logic [7:0] LIM = 8'(STABLE_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [15:0] smp_q, last_q, last_d, cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d, byte_q, byte_d;
  logic [1:0] err_q, err_d;
  logic [4:0] dec_hi, dec_lo;
  function automatic logic [4:0] dec(input logic [7:0] p);
    case (p)
      8'hFD: dec = 5'h00;
      8'h60: dec = 5'h01;
      8'hDA: dec = 5'h02;
      8'hF2: dec = 5'h03;
      8'h66: dec = 5'h04;
      8'hB6: dec = 5'h05;
      8'hBE: dec = 5'h06;
      8'hE0: dec = 5'h07;
      8'hFF: dec = 5'h08;
      8'hF7: dec = 5'h09;
      8'hEC: dec = 5'h0A;
      8'h3E: dec = 5'h0B;
      8'h9C: dec = 5'h0C;
      8'h78: dec = 5'h0D;
      8'h9E: dec = 5'h0E;
      8'h8E: dec = 5'h0F;
      default: dec = 5'h10;
    endcase
  endfunction
  assign dec_hi = dec(cand_q[15:8]);
  assign dec_lo = dec(cand_q[7:0]);
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (smp_q != last_q) begin
        state_d = SETTLE;
        cand_d  = smp_q;
        cnt_d   = 8'd1;
      end
      SETTLE: if (smp_q != cand_q) begin
        cand_d = smp_q;
        cnt_d  = 8'd1;
      end else if (cnt_q < LIM) begin
        cnt_d = cnt_q + 8'd1;
      end else if (cand_q == last_q) begin
        state_d = IDLE;
      end else begin
        state_d = OUTPUT;
        last_d  = cand_q;
        byte_d  = {dec_hi[3:0], dec_lo[3:0]};
        err_d   = {dec_hi[4], dec_lo[4]};
      end
      OUTPUT: state_d = out_ready ? IDLE : OUTPUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      last_q  <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= {seg1_in, seg0_in};
      last_q  <= last_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
    end
  end
  assign out_byte  = byte_q;
  assign out_err   = err_q;
  assign out_valid = state_q == OUTPUT;
endmodule

// File: tb/tb_seg_decode.sv
// tb_seg_decode: directed and random checks of seg_decode at STABLE_CYCLES 4, 2 and 255 against a run-length model
module tb_seg_decode;
  localparam logic [7:0] PAT [16] = '{8'hFD, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                      8'hFF, 8'hF7, 8'hEC, 8'h3E, 8'h9C, 8'h78, 8'h9E, 8'h8E};
  localparam int SV [3] = '{4, 2, 255};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic [7:0] s0 = 8'h00, s1 = 8'h00;
  logic [7:0] ob [3];
  logic [1:0] oe [3];
  logic ov [3];
  int errors = 0, checks = 0;
  int run [3];
  logic [15:0] cur [3], mlast [3];
  logic [15:0] msmp;
  logic mbusy [3];
  logic [7:0] mbyte [3];
  logic [1:0] merr [3];
  int n;
  logic saw;

  always #5 clk = ~clk;

  seg_decode #(.STABLE_CYCLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .seg0_in(s0), .seg1_in(s1),
    .out_byte(ob[0]), .out_err(oe[0]), .out_valid(ov[0]), .out_ready(rdy));
  seg_decode #(.STABLE_CYCLES(2)) dut1 (.clk(clk), .rst_n(rst_n), .seg0_in(s0), .seg1_in(s1),
    .out_byte(ob[1]), .out_err(oe[1]), .out_valid(ov[1]), .out_ready(rdy));
  seg_decode #(.STABLE_CYCLES(255)) dut2 (.clk(clk), .rst_n(rst_n), .seg0_in(s0), .seg1_in(s1),
    .out_byte(ob[2]), .out_err(oe[2]), .out_valid(ov[2]), .out_ready(rdy));

  function automatic logic [4:0] mdec(input logic [7:0] p);
    mdec = 5'h10;
    for (int k = 0; k < 16; k++) if (PAT[k] == p) mdec = {1'b0, 4'(k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A display value is accepted once it has been seen for S consecutive listening samples and differs from the last one accepted.
  task automatic model_edge();
    logic [4:0] h, l;
    if (!rst_n) begin
      msmp = '0;
      for (int i = 0; i < 3; i++) begin
        run[i] = 0; cur[i] = '0; mlast[i] = '0; mbusy[i] = 1'b0; mbyte[i] = '0; merr[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mbusy[i]) begin
          if (rdy) begin mbusy[i] = 1'b0; run[i] = 0; end
        end else begin
          if (run[i] > 0 && msmp == cur[i]) run[i]++;
          else begin cur[i] = msmp; run[i] = 1; end
          if (run[i] == SV[i] && cur[i] != mlast[i]) begin
            h = mdec(cur[i][15:8]);
            l = mdec(cur[i][7:0]);
            mbyte[i] = {h[3:0], l[3:0]};
            merr[i] = {h[4], l[4]};
            mlast[i] = cur[i];
            mbusy[i] = 1'b1;
          end
        end
      end
      msmp = {s1, s0};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_valid%0d", i), 32'(ov[i]), 32'(mbusy[i]));
      chk($sformatf("model_byte%0d", i), 32'(ob[i]), 32'(mbyte[i]));
      chk($sformatf("model_err%0d", i), 32'(oe[i]), 32'(merr[i]));
    end
  endtask

  task automatic wait_valid(input int i, input int lim, output int cnt);
    cnt = 0;
    while (ov[i] !== 1'b1 && cnt < lim) begin step(); cnt++; end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; s1 = 8'hF2; s0 = 8'hEC;
    repeat (3) step();
    chk("reset_valid", 32'(ov[0]), 32'd0);
    chk("reset_byte", 32'(ob[0]), 32'h00);
    chk("reset_err", 32'(oe[0]), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("lat4_k%0d", k), 32'(ov[0]), 32'(k == 5));
      chk($sformatf("lat2_k%0d", k), 32'(ov[1]), 32'(k == 3));
    end
    chk("first_byte", 32'(ob[0]), 32'h3A);
    chk("first_err", 32'(oe[0]), 32'd0);
    step();
    chk("single_pulse", 32'(ov[0]), 32'd0);
    s0 = 8'h3E; saw = 1'b0;
    repeat (2) begin step(); saw |= ov[0]; end
    s0 = 8'hEC;
    repeat (12) begin step(); saw |= ov[0]; end
    chk("glitch_absorbed", 32'(saw), 32'd0);
    s1 = 8'h00; s0 = 8'h60;
    wait_valid(0, 20, n);
    chk("invalid_latency", n, 5);
    chk("invalid_byte", 32'(ob[0]), 32'h01);
    chk("invalid_err", 32'(oe[0]), 32'd2);
    step();
    rdy = 1'b0; s1 = 8'h60; s0 = 8'hDA;
    wait_valid(0, 20, n);
    chk("bp_latency", n, 5);
    chk("bp_byte12", 32'(ob[0]), 32'h12);
    s1 = 8'hF2; s0 = 8'h66;
    repeat (6) step();
    chk("bp_hold_valid", 32'(ov[0]), 32'd1);
    chk("bp_hold_byte", 32'(ob[0]), 32'h12);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("bp_handshake", 32'(ov[0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("bp_next_k%0d", k), 32'(ov[0]), 32'(k == 4));
    end
    chk("bp_byte34", 32'(ob[0]), 32'h34);
    rdy = 1'b1;
    step();
    s1 = 8'hB6; s0 = 8'hBE;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_valid", 32'(ov[0]), 32'd0);
    rst_n = 1'b1;
    wait_valid(0, 20, n);
    chk("rst_mid_latency", n, 5);
    chk("rst_mid_byte", 32'(ob[0]), 32'h56);
    step();
    rst_n = 1'b0; s1 = 8'h9C; s0 = 8'h78;
    step();
    rst_n = 1'b1;
    wait_valid(2, 300, n);
    chk("lat255", n, 256);
    chk("byte255", 32'(ob[2]), 32'hCD);
    step();
    s1 = 8'h9E; s0 = 8'h8E;
    repeat (254) step();
    s1 = 8'h9C; s0 = 8'h78; saw = 1'b0;
    repeat (300) begin step(); saw |= ov[2]; end
    chk("glitch254_absorbed", 32'(saw), 32'd0);
    rst_n = 1'b0; s1 = 8'h00; s0 = 8'h00;
    step();
    rst_n = 1'b1; saw = 1'b0;
    repeat (30) begin step(); saw |= ov[0] | ov[1]; end
    chk("dark_not_emitted", 32'(saw), 32'd0);
    repeat (800) begin
      if ($urandom_range(3) == 0) begin
        s1 = ($urandom_range(7) == 0) ? 8'($urandom) : PAT[$urandom_range(15)];
        s0 = ($urandom_range(7) == 0) ? 8'($urandom) : PAT[$urandom_range(15)];
      end
      rdy = 1'($urandom_range(1));
      rst_n = ($urandom_range(99) != 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_decode.md
SEG_DECODE -- requirements
Module: seg_decode

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..255: consecutive identical samples required before a display value is accepted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port seg0_in, input, 8 bits: raw segment pattern of the low digit.
REQ-005 SHALL have port seg1_in, input, 8 bits: raw segment pattern of the high digit.
REQ-006 SHALL have port out_byte, output, 8 bits: decoded value, {high nibble from seg1, low nibble from seg0}.
REQ-007 SHALL have port out_err, output, 2 bits: bit1 flags an invalid seg1 pattern, bit0 an invalid seg0 pattern.
REQ-008 SHALL have port out_valid, output, 1 bit: out_byte and out_err hold a pending result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-010 SHALL register seg1_in and seg0_in once every cycle into smp = {seg1_q, seg0_q}, 16 bits; all decisions use smp, never the raw ports.
REQ-011 SHALL decode each 8-bit pattern to a nibble using exactly this table:
- FD->0, 60->1, DA->2, F2->3, 66->4, B6->5, BE->6, E0->7
- FF->8, F7->9, EC->A, 3E->B, 9C->C, 78->D, 9E->E, 8E->F
REQ-012 SHALL decode any pattern not in the table to nibble 0 and set the matching out_err bit.
REQ-013 SHALL hold registers last (16 bits, last accepted raw pair), cand (16 bits), and cnt (8 bits).
REQ-014 SHALL implement a three-state FSM: IDLE, SETTLE, OUTPUT.
REQ-015 In IDLE, when smp != last: go to SETTLE with cand=smp and cnt=1; otherwise stay in IDLE.
REQ-016 In SETTLE, when smp != cand: set cand=smp and cnt=1, and stay in SETTLE, restarting the filter.
REQ-017 In SETTLE, when smp == cand and cnt < STABLE_CYCLES-1: increment cnt.
REQ-018 In SETTLE, when smp == cand and cnt == STABLE_CYCLES-1, the SHALL action depends on cand:
- cand == last: go to IDLE, glitch absorbed, nothing emitted.
- otherwise: load out_byte/out_err from decode(cand), set last=cand, go to OUTPUT.
REQ-019 In OUTPUT, out_valid SHALL be 1, and out_byte/out_err SHALL be stable; inputs are sampled into smp but otherwise ignored.
REQ-020 In OUTPUT, when out_ready == 1: go to IDLE, with out_valid low from the next cycle.
REQ-021 out_valid SHALL be 1 exactly when the state is OUTPUT, decoded from a registered state with no combinational path from out_ready.
REQ-022 Latency: a pair first present at the ports before edge E1 and held steady SHALL produce out_valid=1 after edge E(STABLE_CYCLES+1).
REQ-023 A change of the inputs during OUTPUT SHALL be evaluated in IDLE after the handshake, against the updated last.
REQ-024 An unchanged display SHALL never be re-emitted, however long it is held.

Reset
REQ-025 While rst_n == 0 at a rising edge, the block SHALL set:
- state=IDLE, smp=0, last=16'h0000, cand=0, cnt=0;
- out_byte=8'h00, out_err=2'b00, out_valid=0.
REQ-026 Reset SHALL abort SETTLE or OUTPUT mid-operation with no emission.
REQ-027 All-dark 16'h0000 (equal to the reset value of last) SHALL NOT be emitted.

Verification
REQ-028 Reset scenario: hold seg1=F2, seg0=EC with out_ready=1; release reset -> out_valid high after edge E5, out_byte=0x3A, out_err=00, single one-cycle pulse.
REQ-029 Glitch scenario: after 0x3A is accepted, drive 0x3B (seg0=3E) for 2 cycles, then return to 0x3A -> no out_valid.
REQ-030 Invalid-pattern scenario: drive seg1=00, seg0=60 stable -> out_byte=0x01, out_err=10.
REQ-031 Backpressure scenario: with out_ready=0, emit 0x12, then change the inputs to 0x34 while out_valid=1 -> out_byte holds 0x12. Then raise out_ready for one cycle -> 0x34 is emitted STABLE_CYCLES+1 cycles later.
REQ-032 Reset-mid-SETTLE scenario: drive 0x56, assert rst_n=0 at the 2nd SETTLE cycle, release, and keep driving 0x56 -> 0x56 is emitted with full latency counted from release.
REQ-033 Parameter scenario: run with STABLE_CYCLES=2 and 255 -> latency of 3 and 256 edges respectively; a 254-cycle glitch is absorbed at 255.
